// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: conditions raw pushbuttons with a shared tick-based debounce
// engine, detects press and long-press per button, and hands the resulting
// events one at a time to the consumer through a round-robin arbiter and a
// registered valid/ready output stage.
module btn_event_ctrl #(
    parameter int N_BTN          = 4,
    parameter int TICK_DIV       = 50,
    parameter int STABLE_SAMPLES = 3,
    parameter int LONG_TICKS     = 20,
    localparam int W             = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb_in,
    output logic [N_BTN-1:0] btn_level,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [W-1:0]     ev_id,
    output logic             ev_long,
    output logic             ev_drop
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int W1 = W + 1;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } btn_state_e;

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             tick;

    logic [N_BTN-1:0] press_set, long_set;
    logic [N_BTN-1:0] press_pend_q, press_pend_d;
    logic [N_BTN-1:0] long_pend_q, long_pend_d;
    logic [N_BTN-1:0] press_clr, long_clr, eligible;

    logic [W-1:0]     rr_q, rr_d;
    logic             ev_valid_q, ev_valid_d;
    logic [W-1:0]     ev_id_q, ev_id_d;
    logic             ev_long_q, ev_long_d;
    logic             ev_drop_q, ev_drop_d;

    logic             load, found, grant, win_long;
    logic [W-1:0]     win;
    logic [W1-1:0]    cand_w, next_w;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pb_in;
            sync2_q <= sync1_q;
        end
    end

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // Free-running sample tick divider shared by all buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        logic [STABLE_SAMPLES-1:0] hist_q, hist_d;
        btn_state_e                state_q, state_d;
        logic [HW-1:0]             hold_q, hold_d;
        logic                      press_set_b, long_set_b;

        // Debounce FSM and hold counter; both only move on a sample tick,
        // and decisions use the history including the sample just taken.
        always_comb begin
            hist_d      = hist_q;
            state_d     = state_q;
            hold_d      = hold_q;
            press_set_b = 1'b0;
            long_set_b  = 1'b0;
            if (tick) begin
                hist_d = {hist_q[STABLE_SAMPLES-2:0], sync2_q[gi]};
                case (state_q)
                    RELEASED: begin
                        if (&hist_d) begin
                            state_d     = PRESSED;
                            hold_d      = '0;
                            press_set_b = 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (~|hist_d) begin
                            state_d = RELEASED;
                            hold_d  = '0;
                        end else if (hold_q != HW'(LONG_TICKS)) begin
                            // Saturating count makes the long event one-shot.
                            hold_d     = hold_q + HW'(1);
                            long_set_b = (hold_d == HW'(LONG_TICKS));
                        end
                    end
                    default: state_d = RELEASED;
                endcase
            end
        end

        // Per-button debounce state registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hist_q  <= '0;
                state_q <= RELEASED;
                hold_q  <= '0;
            end else begin
                hist_q  <= hist_d;
                state_q <= state_d;
                hold_q  <= hold_d;
            end
        end

        assign press_set[gi] = press_set_b;
        assign long_set[gi]  = long_set_b;
        assign btn_level[gi] = (state_q == PRESSED);
    end

    // Round-robin pick, flag update with loss detection, output stage load.
    always_comb begin
        eligible = press_pend_q | long_pend_q;
        load     = ~ev_valid_q | ev_ready;
        found    = 1'b0;
        win      = '0;
        cand_w   = '0;
        for (int k = 0; k < N_BTN; k++) begin
            cand_w = {1'b0, rr_q} + W1'(k);
            if (cand_w >= W1'(N_BTN)) begin
                cand_w = cand_w - W1'(N_BTN);
            end
            if (!found && eligible[cand_w[W-1:0]]) begin
                found = 1'b1;
                win   = cand_w[W-1:0];
            end
        end
        grant    = load & found;
        win_long = ~press_pend_q[win];

        press_clr = '0;
        long_clr  = '0;
        if (grant) begin
            if (win_long) long_clr[win]  = 1'b1;
            else          press_clr[win] = 1'b1;
        end

        // A set that coincides with a grant of the same flag keeps the flag.
        press_pend_d = press_set | (press_pend_q & ~press_clr);
        long_pend_d  = long_set  | (long_pend_q  & ~long_clr);
        ev_drop_d    = (|(press_set & press_pend_q & ~press_clr)) |
                       (|(long_set  & long_pend_q  & ~long_clr));

        next_w = {1'b0, win} + W1'(1);
        if (next_w >= W1'(N_BTN)) begin
            next_w = '0;
        end
        rr_d = grant ? next_w[W-1:0] : rr_q;

        ev_valid_d = ev_valid_q;
        ev_id_d    = ev_id_q;
        ev_long_d  = ev_long_q;
        if (load) begin
            ev_valid_d = found;
            if (found) begin
                ev_id_d   = win;
                ev_long_d = win_long;
            end
        end
    end

    // Pending flags, arbiter pointer and registered event output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_pend_q <= '0;
            long_pend_q  <= '0;
            rr_q         <= '0;
            ev_valid_q   <= 1'b0;
            ev_id_q      <= '0;
            ev_long_q    <= 1'b0;
            ev_drop_q    <= 1'b0;
        end else begin
            press_pend_q <= press_pend_d;
            long_pend_q  <= long_pend_d;
            rr_q         <= rr_d;
            ev_valid_q   <= ev_valid_d;
            ev_id_q      <= ev_id_d;
            ev_long_q    <= ev_long_d;
            ev_drop_q    <= ev_drop_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_id    = ev_id_q;
    assign ev_long  = ev_long_q;
    assign ev_drop  = ev_drop_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: scenario tasks for btn_event_ctrl, each comparing the DUT
// cycle by cycle against an event-level reference model plus the scenario's
// own fixed expectations.
module tb_btn_event_ctrl;
    localparam int NB = 4;
    localparam int TD = 50;
    localparam int SS = 3;
    localparam int LT = 20;

    logic          clk, rst;
    logic [NB-1:0] pb_in;
    logic [NB-1:0] btn_level;
    logic          ev_valid, ev_ready, ev_long, ev_drop;
    logic [1:0]    ev_id;

    int tests = 0;
    int fails = 0;

    btn_event_ctrl #(
        .N_BTN(NB), .TICK_DIV(TD), .STABLE_SAMPLES(SS), .LONG_TICKS(LT)
    ) dut (
        .clk(clk), .rst(rst), .pb_in(pb_in), .btn_level(btn_level),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id),
        .ev_long(ev_long), .ev_drop(ev_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Debounce expressed as run lengths of agreeing samples, the hold as a
    // tick count since the press, and the arbiter as a distance search.
    int            m_cyc;
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_pp, m_lp;
    int            m_ones[NB];
    int            m_zeros[NB];
    int            m_hold[NB];
    int            m_ptr;
    logic          m_valid, m_long, m_drop;
    logic [1:0]    m_id;

    function automatic bit bitof(logic [NB-1:0] v, int i);
        return ((v >> i) & NB'(1)) != '0;
    endfunction

    function automatic logic [NB-1:0] onehot(int i);
        return NB'(1) << i;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pp = '0; m_lp = '0;
        m_ptr = 0; m_valid = 0; m_long = 0; m_drop = 0; m_id = '0;
        for (int i = 0; i < NB; i++) begin
            m_ones[i] = 0; m_zeros[i] = SS; m_hold[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [NB-1:0] set_p, set_l;
        bit ld, found, wl, lost, gp, gl;
        int win, b;
        set_p = '0; set_l = '0; found = 0; win = 0; lost = 0;
        ld = !m_valid || ev_ready;
        for (int d = 0; d < NB; d++) begin
            b = (m_ptr + d) % NB;
            if (ld && !found && (bitof(m_pp, b) || bitof(m_lp, b))) begin
                found = 1; win = b;
            end
        end
        wl = found && !bitof(m_pp, win);
        if ((m_cyc % TD) == TD - 1) begin
            for (int i = 0; i < NB; i++) begin
                if (bitof(m_s2, i)) begin
                    m_ones[i] = (m_ones[i] < SS) ? m_ones[i] + 1 : SS; m_zeros[i] = 0;
                end else begin
                    m_zeros[i] = (m_zeros[i] < SS) ? m_zeros[i] + 1 : SS; m_ones[i] = 0;
                end
                if (!bitof(m_lvl, i) && m_ones[i] == SS) begin
                    m_lvl = m_lvl | onehot(i); m_hold[i] = 0; set_p = set_p | onehot(i);
                end else if (bitof(m_lvl, i) && m_zeros[i] == SS) begin
                    m_lvl = m_lvl & ~onehot(i); m_hold[i] = 0;
                end else if (bitof(m_lvl, i) && m_hold[i] < LT) begin
                    m_hold[i]++;
                    if (m_hold[i] == LT) set_l = set_l | onehot(i);
                end
            end
        end
        for (int i = 0; i < NB; i++) begin
            gp = found && win == i && !wl;
            gl = found && win == i && wl;
            if (bitof(set_p, i) && bitof(m_pp, i) && !gp) lost = 1;
            if (bitof(set_l, i) && bitof(m_lp, i) && !gl) lost = 1;
            if (bitof(set_p, i)) m_pp = m_pp | onehot(i);
            else if (gp)         m_pp = m_pp & ~onehot(i);
            if (bitof(set_l, i)) m_lp = m_lp | onehot(i);
            else if (gl)         m_lp = m_lp & ~onehot(i);
        end
        m_drop = lost;
        if (ld) begin
            m_valid = found;
            if (found) begin
                m_id = 2'(win); m_long = wl; m_ptr = (win + 1) % NB;
            end
        end
        m_s2 = m_s1; m_s1 = pb_in; m_cyc++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    function automatic logic [8:0] dut_vec();
        return {btn_level, ev_valid, ev_drop, ev_valid ? {ev_long, ev_id} : 3'b000};
    endfunction

    function automatic logic [8:0] mdl_vec();
        return {m_lvl, m_valid, m_drop, m_valid ? {m_long, m_id} : 3'b000};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if ({btn_level, ev_valid, ev_id, ev_long, ev_drop} !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%b want=0", {btn_level, ev_valid, ev_id, ev_long, ev_drop});
        end
        tests++;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_reset t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
        end
    endtask

    task automatic test_clean_press();
        int lat, nev, ndrop, nb;
        logic [2:0] evs[$];
        lat = -1; nev = 0; ndrop = 0;
        ev_ready = 1'b1;
        repeat ($urandom_range(1, TD)) @(negedge clk);
        nb = $urandom_range(2, 6);
        for (int k = 0; k < nb; k++) begin
            pb_in[0] = ~pb_in[0];
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        pb_in[0] = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_press t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
            if (lat < 0 && btn_level[0]) lat = c;
            if (ev_valid && ev_ready) begin nev++; evs.push_back({ev_long, ev_id}); end
            if (ev_drop) ndrop++;
        end
        if (lat < 0 || lat > 153) begin
            fails++; $display("FAIL press_latency got=%0d want<=153", lat);
        end
        tests++;
        if (nev != 1 || evs[0] !== 3'b000) begin
            fails++; $display("FAIL press_event count=%0d first=%b want=1 x 000", nev, nev > 0 ? evs[0] : 3'bxxx);
        end
        tests++;
        if (ndrop != 0) begin
            fails++; $display("FAIL press_drop got=%0d want=0", ndrop);
        end
        tests++;
        pb_in[0] = 1'b0;
        nev = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_release t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
            if (ev_valid) nev++;
        end
        if (btn_level[0] !== 1'b0 || nev != 0) begin
            fails++; $display("FAIL release level=%b events=%0d want 0/0", btn_level[0], nev);
        end
        tests++;
    endtask

    task automatic test_glitch();
        bit saw_lvl, saw_valid;
        saw_lvl = 0; saw_valid = 0;
        repeat ($urandom_range(1, TD)) @(negedge clk);
        pb_in[1] = 1'b1;
        for (int c = 0; c < 590; c++) begin
            if (c == 90) pb_in[1] = 1'b0;
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_glitch t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
            if (btn_level[1]) saw_lvl = 1;
            if (ev_valid) saw_valid = 1;
        end
        if (saw_lvl) begin fails++; $display("FAIL glitch_level got=1 want=0"); end
        tests++;
        if (saw_valid) begin fails++; $display("FAIL glitch_valid got=1 want=0"); end
        tests++;
    endtask

    task automatic test_long_press();
        int t_pv, t_lv;
        logic [2:0] evs[$];
        t_pv = -1; t_lv = -1;
        ev_ready = 1'b1;
        repeat ($urandom_range(1, TD)) @(negedge clk);
        pb_in[2] = 1'b1;
        for (int c = 1; c <= 40 * TD; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_long t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
            if (ev_valid && ev_ready) begin
                evs.push_back({ev_long, ev_id});
                if (!ev_long && t_pv < 0) t_pv = c;
                if (ev_long && t_lv < 0) t_lv = c;
            end
        end
        if (evs.size() != 2 || evs[0] !== 3'b010 || evs[1] !== 3'b110) begin
            fails++; $display("FAIL long_events count=%0d want 2 events 010,110", evs.size());
        end
        tests++;
        if (t_pv < 0 || t_lv - t_pv != LT * TD) begin
            fails++; $display("FAIL long_delay got=%0d want=%0d", t_lv - t_pv, LT * TD);
        end
        tests++;
        pb_in[2] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_long_rel t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
        end
    endtask

    task automatic test_arbitration();
        bit seen;
        int bad, c0;
        logic [2:0] evs[$];
        int cyc[$];
        seen = 0; bad = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ev_ready = 1'b0;
        pb_in = 4'b1010;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_arb_wait t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
            if (ev_valid) seen = 1;
        end
        if (!seen) begin fails++; $display("FAIL arb_wait got=timeout want=ev_valid"); end
        tests++;
        for (int k = 0; k < 10; k++) begin
            if (!(ev_valid === 1'b1 && ev_id === 2'd1 && ev_long === 1'b0)) bad++;
            @(negedge clk);
        end
        if (bad != 0) begin fails++; $display("FAIL arb_hold bad_cycles=%0d want=0", bad); end
        tests++;
        ev_ready = 1'b1;
        if (ev_valid) begin evs.push_back({ev_long, ev_id}); cyc.push_back(0); end
        for (int c = 1; c <= 300; c++) begin
            if (c == 5) pb_in[0] = 1'b1;
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_arb t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
            if (ev_valid && ev_ready) begin evs.push_back({ev_long, ev_id}); cyc.push_back(c); end
        end
        if (evs.size() != 3 || evs[0] !== 3'b001 || evs[1] !== 3'b011 || evs[2] !== 3'b000) begin
            fails++; $display("FAIL arb_order count=%0d want ids 1,3,0", evs.size());
        end
        tests++;
        c0 = (cyc.size() >= 2) ? cyc[1] - cyc[0] : -1;
        if (c0 != 1) begin fails++; $display("FAIL arb_back_to_back gap=%0d want=1", c0); end
        tests++;
        pb_in = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_arb_rel t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
        end
    endtask

    task automatic test_drop();
        int ndrop, bad, nev;
        bit held;
        ndrop = 0; bad = 0; nev = 0; held = 0;
        ev_ready = 1'b0;
        // First press occupies the output register, the second waits in its
        // flag and the third finds the flag still set and is lost.
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 500; c++) begin
                pb_in[0] = (c < 250);
                @(negedge clk);
                if (dut_vec() !== mdl_vec()) begin
                    fails++; $display("FAIL lockstep_drop t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
                end
                tests++;
                if (ev_drop) ndrop++;
                if (ev_valid) held = 1;
                if (held && !(ev_valid === 1'b1 && ev_id === 2'd0 && ev_long === 1'b0)) bad++;
            end
        end
        if (ndrop != 1) begin fails++; $display("FAIL drop_pulses got=%0d want=1", ndrop); end
        tests++;
        if (!held || bad != 0) begin fails++; $display("FAIL drop_hold held=%0d bad=%0d want 1/0", held, bad); end
        tests++;
        ev_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (ev_valid && ev_ready && ev_id === 2'd0 && ev_long === 1'b0) nev++;
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_drop_drain t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
        end
        if (nev != 2) begin fails++; $display("FAIL drop_delivered got=%0d want=2", nev); end
        tests++;
    endtask

    task automatic test_reset_mid_hold();
        bit seen;
        int lat;
        logic [2:0] ev;
        seen = 0; lat = -1; ev = '0;
        ev_ready = 1'b1;
        pb_in[3] = 1'b1;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_mid_wait t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
            if (ev_valid) seen = 1;
        end
        for (int c = 0; c < 10 * TD; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_mid_hold t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
        end
        rst = 1'b1;
        #1;
        if ({btn_level, ev_valid, ev_id, ev_long, ev_drop} !== 9'd0) begin
            fails++; $display("FAIL mid_reset_outputs got=%b want=0", {btn_level, ev_valid, ev_id, ev_long, ev_drop});
        end
        tests++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_mid_after t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
            if (lat < 0 && ev_valid) begin lat = c; ev = {ev_long, ev_id}; end
        end
        if (lat < (SS - 1) * TD || lat > 2 + SS * TD + 1 || ev !== 3'b011) begin
            fails++; $display("FAIL mid_reset_requal lat=%0d ev=%b want lat in [100,153] ev=011", lat, ev);
        end
        tests++;
        pb_in[3] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_mid_rel t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
        end
    endtask

    task automatic test_random();
        int xfers, drops;
        xfers = 0; drops = 0;
        for (int c = 0; c < 20000; c++) begin
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 119) == 0) pb_in = pb_in ^ onehot(b);
            end
            ev_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_random t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
            if (ev_valid && ev_ready) xfers++;
            if (ev_drop) drops++;
        end
        $display("[TB] random soak: %0d transfers, %0d drop pulses", xfers, drops);
        pb_in = '0;
        ev_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (dut_vec() !== mdl_vec()) begin
                fails++; $display("FAIL lockstep_random_drain t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
            tests++;
        end
    endtask

    initial begin
        rst = 1'b1;
        pb_in = '0;
        ev_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_long_press();
        test_arbitration();
        test_drop();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
